// File: rtl/mem_access_stage.sv
// mem_access_stage -- MEM stage of the integer pipeline with the MEM/WB register.
//
// Non-memory ops move into MEM/WB in one cycle. A load or store latches its
// address, byte enables and store data at the IDLE edge and moves to REQ.
// In REQ the stage holds dm_req until dm_ack. On the ack edge, MEM/WB
// captures the load result or the store address.
//
// Optional feature: define MEMWB_MISALIGN_CHK_EN to trap misaligned half/word
// accesses. Such an access gets no memory request. It retires in one cycle
// with rf write suppressed and misalign pulsed. When the macro is undefined,
// misalign is tied low and the low address bits that the access size does not
// use are ignored.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   ex_valid             EX/MEM holds a valid instruction
//   ex_alu_c[31:0]       ALU result / byte address
//   ex_rd[4:0]           destination register
//   ex_store_data[31:0]  store data
//   ex_rf_wr             register-write control
//   ex_mem_rd            load control
//   ex_mem_wr            store control (wins if both are set)
//   ex_size[1:0]         00 byte, 01 half, 1x word
//   ex_unsigned          zero-extend loads
//   dm_req, dm_we        data-memory request / write enable
//   dm_addr[31:0]        word-aligned address
//   dm_wdata[31:0]       lane-replicated store data
//   dm_be[3:0]           byte enables
//   dm_rdata[31:0]       read data
//   dm_ack               completion, sampled in REQ only
//   stall                hold upstream pipeline registers
//   wb_valid, wb_rf_wr   MEM/WB valid and register write
//   wb_rd[4:0]           MEM/WB destination register
//   wb_data[31:0]        MEM/WB data
//   misalign             one-cycle misaligned-access flag
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_c,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_store_data,
  input  logic        ex_rf_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_rf_wr,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state_q, state_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [4:0]  lat_rd_q, lat_rd_d;
  logic        lat_rf_wr_q, lat_rf_wr_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic        lat_uns_q, lat_uns_d;
  logic [1:0]  lat_lo_q, lat_lo_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rf_wr_q, wb_rf_wr_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        stall_c;
  logic        mem_op_c;
  logic        mis_c;

  // Byte enables for an access of the given size at the given low address bits.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the enabled lane carries it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Lane select plus sign/zero extension of the returned read word.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

`ifdef MEMWB_MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      default: m = |lo;
    endcase
    return m;
  endfunction

  assign mis_c = is_misaligned(ex_size, ex_alu_c[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  assign mem_op_c = ex_mem_rd | ex_mem_wr;

  always_comb begin
    state_d     = state_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_be_d     = dm_be_q;
    lat_rd_d    = lat_rd_q;
    lat_rf_wr_d = lat_rf_wr_q;
    lat_size_d  = lat_size_q;
    lat_uns_d   = lat_uns_q;
    lat_lo_d    = lat_lo_q;
    wb_valid_d  = 1'b0;
    wb_rf_wr_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    stall_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (mem_op_c && mis_c) begin
            // Trapped access: retire now, no memory traffic, no register write.
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_c;
          end else if (mem_op_c) begin
            stall_c     = 1'b1;
            dm_we_d     = ex_mem_wr;
            dm_addr_d   = {ex_alu_c[31:2], 2'b00};
            dm_be_d     = byte_en(ex_size, ex_alu_c[1:0]);
            dm_wdata_d  = store_lanes(ex_size, ex_store_data);
            lat_rd_d    = ex_rd;
            lat_rf_wr_d = ex_rf_wr;
            lat_size_d  = ex_size;
            lat_uns_d   = ex_unsigned;
            lat_lo_d    = ex_alu_c[1:0];
            state_d     = S_REQ;
          end else begin
            wb_valid_d = 1'b1;
            wb_rf_wr_d = ex_rf_wr & (|ex_rd);
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_c;
          end
        end
      end
      S_REQ: begin
        stall_c = ~dm_ack;
        if (dm_ack) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = lat_rd_q;
          if (dm_we_q) begin
            wb_rf_wr_d = 1'b0;
            wb_data_d  = {dm_addr_q[31:2], lat_lo_q};
          end else begin
            wb_rf_wr_d = lat_rf_wr_q & (|lat_rd_q);
            wb_data_d  = load_extract(dm_rdata, lat_size_q, lat_lo_q, lat_uns_q);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MEM -> MEM/WB register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'h0;
      dm_wdata_q  <= 32'h0;
      dm_be_q     <= 4'h0;
      lat_rd_q    <= 5'h0;
      lat_rf_wr_q <= 1'b0;
      lat_size_q  <= 2'b00;
      lat_uns_q   <= 1'b0;
      lat_lo_q    <= 2'b00;
      wb_valid_q  <= 1'b0;
      wb_rf_wr_q  <= 1'b0;
      wb_rd_q     <= 5'h0;
      wb_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_be_q     <= dm_be_d;
      lat_rd_q    <= lat_rd_d;
      lat_rf_wr_q <= lat_rf_wr_d;
      lat_size_q  <= lat_size_d;
      lat_uns_q   <= lat_uns_d;
      lat_lo_q    <= lat_lo_d;
      wb_valid_q  <= wb_valid_d;
      wb_rf_wr_q  <= wb_rf_wr_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

`ifdef MEMWB_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = (state_q == S_IDLE) & ex_valid & mem_op_c & mis_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  // stall is combinational from the EX inputs, so gate it while reset is held.
  assign stall    = stall_c & ~rst;
  assign dm_req   = (state_q == S_REQ);
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_be    = dm_be_q;
  assign wb_valid = wb_valid_q;
  assign wb_rf_wr = wb_rf_wr_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule
